// File: rtl/elev_req_sched_if.sv
// rtl/elev_req_sched_if.sv - call-button / floor-sensor / request bundle for elev_req_sched
interface elev_req_sched_if;
  logic [3:1] Btn;
  logic       FLR1;
  logic       FLR2;
  logic       FLR3;
  logic       Door;
  logic [3:1] Req;
  logic [3:1] Pending;
  logic       DirUp;

  modport slave (
    input  Btn, FLR1, FLR2, FLR3, Door,
    output Req, Pending, DirUp
  );

  modport master (
    output Btn, FLR1, FLR2, FLR3, Door,
    input  Req, Pending, DirUp
  );
endinterface

// File: rtl/elev_req_sched.sv
// rtl/elev_req_sched.sv - debounced call latching and SCAN target selection for the elevator controller
module elev_req_sched #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             Reset,
  elev_req_sched_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  logic [3:1]       sync1_q, sync1_d;
  logic [3:1]       sync2_q, sync2_d;
  logic [3:1]       deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [3:1];
  logic [CNT_W-1:0] cnt_d [3:1];
  logic [1:0]       floor_q, floor_d;
  logic [1:0]       state_q, state_d;
  logic [3:1]       pending_q, pending_d;
  logic [3:1]       req_q, req_d;
  logic             dir_q, dir_d;

  logic [3:1] rise, cur_oh, above_m, below_m, clr, pend_above, pend_below;
  logic       has_above, has_below;

  always_comb begin
    sync1_d = bus.Btn;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 1; i <= 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEB_CYCLES)) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    rise = deb_d & ~deb_q;

    // Tracked floor only moves on an unambiguous one-hot sensor reading
    case ({bus.FLR3, bus.FLR2, bus.FLR1})
      3'b001:  floor_d = 2'd1;
      3'b010:  floor_d = 2'd2;
      3'b100:  floor_d = 2'd3;
      default: floor_d = floor_q;
    endcase

    case (floor_d)
      2'd1:    begin cur_oh = 3'b001; above_m = 3'b110; below_m = 3'b000; end
      2'd2:    begin cur_oh = 3'b010; above_m = 3'b100; below_m = 3'b001; end
      default: begin cur_oh = 3'b100; above_m = 3'b000; below_m = 3'b011; end
    endcase

    // Service clear beats a simultaneous press at the same floor
    clr        = bus.Door ? cur_oh : 3'b000;
    pending_d  = (pending_q | rise) & ~clr;
    pend_above = pending_d & above_m;
    pend_below = pending_d & below_m;
    has_above  = |pend_above;
    has_below  = |pend_below;

    state_d = state_q;
    case (state_q)
      ST_UP: begin
        if (has_above)            state_d = ST_UP;
        else if (has_below)       state_d = ST_DOWN;
        else if (pending_d == '0) state_d = ST_IDLE;
      end
      ST_DOWN: begin
        if (has_below)            state_d = ST_DOWN;
        else if (has_above)       state_d = ST_UP;
        else if (pending_d == '0) state_d = ST_IDLE;
      end
      default: begin
        if (has_above)            state_d = ST_UP;
        else if (has_below)       state_d = ST_DOWN;
        else                      state_d = ST_IDLE;
      end
    endcase

    dir_d = dir_q;
    if (state_d == ST_UP)   dir_d = 1'b1;
    if (state_d == ST_DOWN) dir_d = 1'b0;

    req_d = 3'b000;
    if (bus.Door) begin
      req_d = 3'b000;
    end else if (|(pending_d & cur_oh)) begin
      req_d = cur_oh;
    end else if (state_d == ST_UP) begin
      if (pend_above[2])      req_d = 3'b010;
      else if (pend_above[3]) req_d = 3'b100;
    end else if (state_d == ST_DOWN) begin
      if (pend_below[2])      req_d = 3'b010;
      else if (pend_below[1]) req_d = 3'b001;
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      for (int i = 1; i <= 3; i++) cnt_q[i] <= '0;
      floor_q   <= 2'd1;
      state_q   <= ST_IDLE;
      pending_q <= '0;
      req_q     <= '0;
      dir_q     <= 1'b1;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      for (int i = 1; i <= 3; i++) cnt_q[i] <= cnt_d[i];
      floor_q   <= floor_d;
      state_q   <= state_d;
      pending_q <= pending_d;
      req_q     <= req_d;
      dir_q     <= dir_d;
    end
  end

  assign bus.Req     = req_q;
  assign bus.Pending = pending_q;
  assign bus.DirUp   = dir_q;

endmodule

// File: doc/elev_req_sched.md
Name: elev_req_sched

Overview:
- Upstream stage of the three-floor elevator controller.
- Synchronises and debounces the raw floor call buttons, and latches them as pending calls.
- Picks a single target floor with a direction-preserving (SCAN) policy and drives the controller's one-hot Req input.
- Clears a pending call when the controller reports the door open at that floor, via FLR1..FLR3 and Door.

Parameters:
- DEB_CYCLES, 4: consecutive stable synchronised samples required to accept a button level change; legal range 1..15.
- CNT_W, 4: debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk  input  1  rising-edge clock shared with the controller
- Reset  input  1  synchronous, active-low reset
- Btn  input  3  raw call buttons, bit n = floor n (index [3:1]); asynchronous, may bounce
- FLR1  input  1  controller: car at floor 1
- FLR2  input  1  controller: car at floor 2
- FLR3  input  1  controller: car at floor 3
- Door  input  1  controller: door open
- Req  output  3  target floor to controller, one-hot or 3'b000, index [3:1]; registered
- Pending  output  3  latched outstanding calls, index [3:1]; registered
- DirUp  output  1  current sweep direction, 1 = up; registered

Behaviour:
- Reset (Reset==0 at a clk edge):
  - Req=000, Pending=000, DirUp=1.
  - Sync flops, debounced levels and debounce counters cleared.
  - Tracked floor = 1; state = IDLE.
- Reset mid-operation discards all pending calls; a button still held after release of reset re-registers as a new press.
- Synchroniser: 2 flops per Btn bit.
- Debounce, per bit:
  - Counter increments while the sync output differs from the debounced level, and clears when they match.
  - At count == DEB_CYCLES the debounced level flips and the counter clears.
- Press latency: a Btn bit held steady high from edge k makes the debounced rise visible at edge k+2+DEB_CYCLES. Pending sets on that same edge; Req can reflect it one edge later.
- Only a debounced rising edge sets Pending; holding a button does not re-trigger.
- Tracked floor:
  - Updated when exactly one of FLR1..3 is high.
  - Zero or multiple asserted bits: hold the previous tracked floor.
- Service clear:
  - Pending[f] clears on any edge where Door==1 and the tracked floor == f.
  - Clear has priority over a simultaneous set for the same floor.
  - A press at the current floor while the door is open is therefore dropped.
- States: IDLE, UP, DOWN. DirUp=1 in UP, 0 in DOWN, and holds its last value in IDLE.
  - IDLE: Pending==0 → stay. Pending at the current floor only → stay and serve. Otherwise go to UP if any pending floor is above, else DOWN. A call above wins when calls exist both above and below.
  - UP: pending above → stay. None above but some below → DOWN. Pending==0 → IDLE.
  - DOWN: mirror of UP.
- Req (registered, recomputed every edge from the next-state Pending/state):
  - Door==1 → Req=000.
  - Else if Pending[current] → Req = one-hot of the current floor.
  - Else in UP → nearest pending floor above; in DOWN → nearest pending floor below.
  - Else 000.
- Req is never multi-hot.
- Req never targets a floor without a pending call, except one-cycle latency artefacts after a clear; the Door gate covers these.
- Boundaries:
  - Floor 3 has no "above", floor 1 has no "below"; reversal logic handles both.
  - All three buttons accepted on the same edge set all Pending bits together.

Test Plan:
- Reset → all outputs 0 except DirUp=1. Hold Btn=111 through reset release → Pending=111 exactly 2+DEB_CYCLES edges after release.
- Car at floor 1 (FLR1=1, Door=0), clean press Btn[3] → Pending=100, then Req=100 and DirUp=1. Drive FLR3=1, Door=1 → Pending=000 and Req=000 on the next edge; state reaches IDLE.
- Car at floor 2 in UP, Pending=101 → Req=100. After floor 3 is served → DOWN, Req=001, DirUp=0.
- Btn[2] glitches: high 3 cycles, low, then high 3 cycles with DEB_CYCLES=4 → Pending stays 000. Then held 6 cycles → Pending=010.
- Door=1 at floor 2 while a debounced Btn[2] rise lands on the same edge → Pending[2] stays 0 and Req=000.
- Pending=111, assert Reset for one edge mid-travel → Req=000, Pending=000, DirUp=1, tracked floor=1 the next cycle.
